latch_arb: RTL and testbench

LATCH_ARB -- requirements
Module: latch_arb

---
 rtl/latch_arb_pkg.sv | 24 ++
 rtl/latch_arb_hold_cnt.sv | 44 ++++
 rtl/latch_arb.sv | 109 ++++++++++
 tb/tb_latch_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_arb_pkg.sv
// -----------------------------------------------------------------------------
// latch_arb_pkg
// Shared definitions for the two-requester latch arbiter: the arbiter FSM
// state type, the requester count, and the helper that sizes the hold counter.
// No ports (package).
// -----------------------------------------------------------------------------
package latch_arb_pkg;

    // Number of requesters this revision of the arbiter supports
    localparam int NUM_REQ = 2;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Hold counter must be able to represent MAX_HOLD itself
    function automatic int cnt_width(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/latch_arb_hold_cnt.sv
// -----------------------------------------------------------------------------
// latch_arb_hold_cnt
// Saturating hold counter that measures how long the current grant has been
// asserted. Loading starts a new grant at 1; incrementing stops at MAX_HOLD.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (count -> 0)
//   load   in   start of a grant, count -> 1
//   inc    in   grant held another cycle, count + 1 (saturating)
//   at_max out  count has reached MAX_HOLD
// -----------------------------------------------------------------------------
module latch_arb_hold_cnt
    import latch_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic at_max
);

    localparam int               CNT_W   = cnt_width(MAX_HOLD);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

    logic [CNT_W-1:0] count;

    // Count grant cycles; load wins over increment, and the count never
    // wraps past MAX_HOLD so at_max stays stable if inc lingers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (inc && (count != MAX_CNT)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_max = (count == MAX_CNT);

endmodule

// File: rtl/latch_arb.sv
// -----------------------------------------------------------------------------
// latch_arb
// Round-robin arbiter for a shared latch between two requesters. A grant is
// held while the owner keeps requesting, up to MAX_HOLD cycles, and is always
// followed by at least one all-zero cycle before the next grant.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   request  in   per-requester level request
//   grant    out  one-hot-or-zero registered grant
//   owner    out  index of the current or most recent grantee
//   busy     out  high while grant is non-zero
//   timeout  out  one-cycle pulse when a grant is revoked at MAX_HOLD
// -----------------------------------------------------------------------------
module latch_arb #(
    parameter int MAX_HOLD = 8,
    parameter int NUM_REQ  = latch_arb_pkg::NUM_REQ
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] request,
    output logic [NUM_REQ-1:0] grant,
    output logic               owner,
    output logic               busy,
    output logic               timeout
);

    import latch_arb_pkg::*;

    arb_state_t state;
    logic       last_owner;
    logic       pick;
    logic       cnt_load;
    logic       cnt_inc;
    logic       at_max;

    // Choose the next grantee from IDLE: a lone requester always wins,
    // a tie goes to whoever did not hold the latch last.
    always_comb begin
        pick = request[1];
        if (&request) begin
            pick = ~last_owner;
        end
    end

    // Counter control mirrors the FSM transitions below: load on the
    // IDLE->GRANT edge, count while the owner keeps its request up.
    assign cnt_load = (state == IDLE) && (|request);
    assign cnt_inc  = (state == GRANT) && request[owner];

    latch_arb_hold_cnt #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_cnt (
        .clk    (clk),
        .rst    (rst),
        .load   (cnt_load),
        .inc    (cnt_inc),
        .at_max (at_max)
    );

    // Arbiter FSM with all outputs registered. Release by the owner takes
    // priority over the hold limit, so a voluntary drop never pulses timeout.
    // GAP forces a zero-grant cycle between consecutive grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|request) begin
                        state      <= GRANT;
                        grant      <= NUM_REQ'(1) << pick;
                        busy       <= 1'b1;
                        owner      <= pick;
                        last_owner <= pick;
                    end
                end
                GRANT: begin
                    if (!request[owner]) begin
                        state <= GAP;
                        grant <= '0;
                        busy  <= 1'b0;
                    end else if (at_max) begin
                        state   <= GAP;
                        grant   <= '0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_arb.sv
// -----------------------------------------------------------------------------
// tb_latch_arb
// Self-checking bench for latch_arb: directed vectors on a MAX_HOLD=8 and a
// MAX_HOLD=1 instance, followed by a long random-request run with property
// checks on grant shape, hold length, timeout and fairness.
// -----------------------------------------------------------------------------
module tb_latch_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] request;
    logic [1:0] grant;
    logic       owner;
    logic       busy;
    logic       timeout;
    logic [1:0] request1;
    logic [1:0] grant1;
    logic       owner1;
    logic       busy1;
    logic       timeout1;

    int checks = 0;
    int errors = 0;

    latch_arb #(.MAX_HOLD(8), .NUM_REQ(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .request (request),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    latch_arb #(.MAX_HOLD(1), .NUM_REQ(2)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .request (request1),
        .grant   (grant1),
        .owner   (owner1),
        .busy    (busy1),
        .timeout (timeout1)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value is wrong
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive a request pattern on the MAX_HOLD=8 instance and advance one cycle
    task automatic applyStimulus(input logic [1:0] req);
        request = req;
        stepCycle();
    endtask

    // Check the full output set of the MAX_HOLD=8 instance
    task automatic checkArb(input string tag, input logic [1:0] expGrant,
                            input logic expOwner, input logic expTimeout);
        checkOutput({tag, ".grant"}, grant, expGrant);
        checkOutput({tag, ".owner"}, owner, expOwner);
        checkOutput({tag, ".busy"}, busy, |expGrant);
        checkOutput({tag, ".timeout"}, timeout, expTimeout);
    endtask

    task automatic doReset();
        rst      = 1'b1;
        request  = 2'b00;
        request1 = 2'b00;
        stepCycle();
        stepCycle();
        rst = 1'b0;
    endtask

    // Watchdog so the run can never hang
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] expG1 [10];
        logic       expT1 [10];
        logic [1:0] prevGrant;
        logic [1:0] reqAtEdge;
        logic       expTo;
        int         runLen;
        int         prevRunLen;
        int         waitCnt [2];

        request  = 2'b00;
        request1 = 2'b00;
        rst      = 1'b1;

        // Reset state
        doReset();
        checkArb("reset", 2'b00, 1'b0, 1'b0);
        checkOutput("reset.grant1", grant1, 2'b00);

        // Both requesting: requester 0 first, timeout after 8, then requester 1
        $display("[TB] tie with MAX_HOLD=8");
        applyStimulus(2'b11);
        checkArb("tie.c1", 2'b01, 1'b0, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            applyStimulus(2'b11);
            checkArb("tie.hold", 2'b01, 1'b0, 1'b0);
        end
        applyStimulus(2'b11);
        checkArb("tie.c9", 2'b00, 1'b0, 1'b1);
        applyStimulus(2'b11);
        checkArb("tie.c10", 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b11);
        checkArb("tie.c11", 2'b10, 1'b1, 1'b0);

        // Voluntary release after 3 cycles: no timeout
        $display("[TB] short single request");
        doReset();
        applyStimulus(2'b01);
        checkArb("short.c1", 2'b01, 1'b0, 1'b0);
        applyStimulus(2'b01);
        checkArb("short.c2", 2'b01, 1'b0, 1'b0);
        applyStimulus(2'b01);
        checkArb("short.c3", 2'b01, 1'b0, 1'b0);
        applyStimulus(2'b00);
        checkArb("short.c4", 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00);
        checkArb("short.c5", 2'b00, 1'b0, 1'b0);

        // Alternating single requesters, each dropped after 2 granted cycles
        $display("[TB] alternating requesters");
        doReset();
        applyStimulus(2'b01);
        checkArb("alt.c1", 2'b01, 1'b0, 1'b0);
        applyStimulus(2'b01);
        checkArb("alt.c2", 2'b01, 1'b0, 1'b0);
        applyStimulus(2'b10);
        checkArb("alt.c3", 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b10);
        checkArb("alt.c4", 2'b00, 1'b0, 1'b0);
        applyStimulus(2'b10);
        checkArb("alt.c5", 2'b10, 1'b1, 1'b0);
        applyStimulus(2'b10);
        checkArb("alt.c6", 2'b10, 1'b1, 1'b0);
        applyStimulus(2'b01);
        checkArb("alt.c7", 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b01);
        checkArb("alt.c8", 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b01);
        checkArb("alt.c9", 2'b01, 1'b0, 1'b0);
        applyStimulus(2'b01);
        checkArb("alt.c10", 2'b01, 1'b0, 1'b0);
        applyStimulus(2'b00);
        checkArb("alt.c11", 2'b00, 1'b0, 1'b0);

        // MAX_HOLD=1 with constant tie: one-cycle grants, timeout on each revoke
        $display("[TB] MAX_HOLD=1 tie");
        doReset();
        expG1 = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
        expT1 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        request1 = 2'b11;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            checkOutput($sformatf("mh1.grant[%0d]", i), grant1, expG1[i]);
            checkOutput($sformatf("mh1.timeout[%0d]", i), timeout1, expT1[i]);
            checkOutput($sformatf("mh1.busy[%0d]", i), busy1, |expG1[i]);
        end
        checkOutput("mh1.owner", owner1, 1'b1);
        request1 = 2'b00;

        // Reset during the 4th granted cycle of requester 1
        $display("[TB] reset mid-grant");
        doReset();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(i == 1 ? 2'b10 : 2'b11);
            checkArb("rstmid.hold", 2'b10, 1'b1, 1'b0);
        end
        rst = 1'b1;
        stepCycle();
        checkArb("rstmid.drop", 2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(2'b11);
        checkArb("rstmid.after", 2'b01, 1'b0, 1'b0);

        // Random requests with property checks
        $display("[TB] random run");
        doReset();
        prevGrant  = 2'b00;
        runLen     = 0;
        waitCnt[0] = 0;
        waitCnt[1] = 0;
        for (int n = 0; n < 10000; n++) begin
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(0, 7) == 0) begin
                    request[b] = ~request[b];
                end
            end
            reqAtEdge = request;
            stepCycle();
            prevRunLen = runLen;
            if (grant == 2'b00) begin
                runLen = 0;
            end else if (grant == prevGrant) begin
                runLen = runLen + 1;
            end else begin
                runLen = 1;
            end
            expTo = (prevGrant != 2'b00) && (grant == 2'b00) && (prevRunLen == 8) &&
                    reqAtEdge[prevGrant[1]];
            checkOutput("rand.onehot0", $onehot0(grant), 1'b1);
            checkOutput("rand.busy", busy, |grant);
            checkOutput("rand.holdLen", runLen <= 8, 1'b1);
            checkOutput("rand.gapBetween",
                        (prevGrant == 2'b00) || (grant == 2'b00) || (grant == prevGrant), 1'b1);
            checkOutput("rand.timeout", timeout, expTo);
            for (int b = 0; b < 2; b++) begin
                if (reqAtEdge[b] && !grant[b]) begin
                    waitCnt[b] = waitCnt[b] + 1;
                end else begin
                    waitCnt[b] = 0;
                end
                checkOutput($sformatf("rand.starve%0d", b), waitCnt[b] <= 20, 1'b1);
            end
            prevGrant = grant;
        end
        request = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
